inv_park: RTL
=============

INV_PARK -- requirements
Module: inv_park

Interface
REQ-001 The block SHALL have parameter OUT_LIMIT, default 32767, the symmetric saturation magnitude applied to both outputs; the legal range is 1..32767.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port s_vdq_tdata, input, 32 bits: {vd[31:16], vq[15:0]}, each signed Q1.15.
REQ-005 The block SHALL have port s_vdq_tvalid, input, 1 bit: when high, s_vdq_tdata is loaded into the vdq holding register.
REQ-006 The block SHALL have port sin_cos_tdata, input, 34 bits: {sin[33:17], cos[16:0]}, each signed 17-bit Q2.15, covering ±1.0 inclusive.
REQ-007 The block SHALL have port sin_cos_tvalid, input, 1 bit: a one-cycle pulse that triggers one transform.
REQ-008 The block SHALL have port alpha_beat_tdata, output, 32 bits: {alpha[31:16], beta[15:0]}, each signed Q1.15; this is the SVPWM input format.
REQ-009 The block SHALL have port alpha_beat_tvalid, output, 1 bit: a one-cycle pulse; there is no backpressure.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a transform is in flight.
REQ-011 The block SHALL have port overrun, output, 1 bit: a sticky flag that is set when a trigger is dropped.

Function
REQ-012 The block SHALL compute alpha = vd*cos - vq*sin and beta = vd*sin + vq*cos.
REQ-013 The block SHALL use one shared registered 16x17 signed multiplier, with 33-bit products and 34-bit sums.
REQ-014 The FSM SHALL have the states IDLE, M0, M1, M2, M3, SUM and OUT.
REQ-015 In IDLE, a sin_cos_tvalid pulse SHALL latch sin, cos and the current vdq, then move to M0.
REQ-016 States M0 to M3 SHALL each issue exactly one product, in the order vd*cos, vq*sin, vd*sin, vq*cos, and each state SHALL advance unconditionally.
REQ-017 SUM SHALL form each 34-bit sum, add 2^14, arithmetic-shift right by 15, and saturate the result to [-OUT_LIMIT, +OUT_LIMIT].
REQ-018 OUT SHALL register the result and return to IDLE.
REQ-019 Latency SHALL be fixed: a trigger sampled at edge N SHALL give alpha_beat_tvalid high for exactly the cycle following edge N+6.
REQ-020 alpha_beat_tdata SHALL hold its last value until the next OUT state.
REQ-021 If s_vdq_tvalid and sin_cos_tvalid are high in the same cycle, the new vdq value SHALL be used for that transform.
REQ-022 The latched operands SHALL NOT be affected by s_vdq_tvalid or sin_cos_tdata changes while busy is high.
REQ-023 busy SHALL be high in every state from M0 through OUT inclusive.
REQ-024 A sin_cos_tvalid arriving while busy is high SHALL be dropped, SHALL set overrun, and SHALL NOT alter the transform in flight.
REQ-025 overrun SHALL be cleared only by rst.
REQ-026 Inputs of exactly ±1.0 (sin or cos = ±32768) SHALL be handled without overflow before saturation.

Reset
REQ-027 While rst is high, the FSM SHALL go to IDLE, and busy, overrun and alpha_beat_tvalid SHALL all be 0.
REQ-028 While rst is high, alpha_beat_tdata, the vdq register and the latched operands SHALL all be 0.
REQ-029 An rst asserted mid-transform SHALL abort it, with no alpha_beat_tvalid pulse after reset.
REQ-030 A trigger arriving in the same cycle as rst SHALL be ignored.

Structure
REQ-031 Shared package foc_pkg SHALL hold the constants Q_FRAC = 15, DATA_W = 16 and ANGLE_W = 17.
REQ-032 foc_pkg SHALL hold the sin_cos and alpha_beat field-offset constants and the saturate/round function, so that SVPWM and sin_cos reuse them.
REQ-033 The multiplier SHALL be one sub-module, mul_s16x17: one register stage, signed 16x17 to 33 bits, with an enable.

Verification
REQ-034 Scenario "d-axis at zero angle": vd = 16384, vq = 0, sin = 0, cos = 32768, trigger at edge N -> alpha_beat_tvalid at N+6 with alpha = 16384 and beta = 0.
REQ-035 Scenario "q-axis at 90 degrees": vd = 0, vq = 16384, sin = 32768, cos = 0 -> alpha = -16384, beta = 0.
REQ-036 Scenario "saturation": vd = vq = 32767, sin = cos = 23170 -> alpha = 0, beta = 32767 (saturated); repeated with OUT_LIMIT = 30000 -> beta = 30000.
REQ-037 Scenario "overrun": a second trigger 3 cycles after the first -> exactly one output pulse, with the first transform's values, and overrun = 1 until rst.
REQ-038 Scenario "reset mid-operation": rst high at N+3 -> no pulse for 10 cycles afterwards, and busy = 0, overrun = 0, tdata = 0.
REQ-039 Scenario "simultaneous update": vdq = (16384, 0) held, then s_vdq_tvalid with vd = 8192 in the same cycle as the trigger (sin = 0, cos = 32768) -> alpha = 8192; a vdq write during busy does not change the result.

Source files
------------

// File: rtl/foc_pkg.sv
// Shared FOC constants, stream field offsets and the Q1.15 round/saturate helper.
// Used by inv_park and intended for reuse by the SVPWM and sin_cos blocks.
package foc_pkg;

    localparam int Q_FRAC  = 15;
    localparam int DATA_W  = 16;
    localparam int ANGLE_W = 17;
    localparam int PROD_W  = DATA_W + ANGLE_W;
    localparam int SUM_W   = PROD_W + 1;

    localparam int SC_W        = 2 * ANGLE_W;
    localparam int SC_COS_LSB  = 0;
    localparam int SC_SIN_LSB  = ANGLE_W;

    localparam int AB_W         = 2 * DATA_W;
    localparam int AB_BETA_LSB  = 0;
    localparam int AB_ALPHA_LSB = DATA_W;

    localparam int VDQ_VQ_LSB = 0;
    localparam int VDQ_VD_LSB = DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_SUM,
        ST_OUT
    } inv_park_state_e;

    // Round half up at the Q_FRAC boundary, then clamp symmetrically to +/-limit.
    function automatic logic signed [DATA_W-1:0] round_sat(
        input logic signed [SUM_W-1:0] s,
        input int                      limit
    );
        logic signed [SUM_W-1:0] rnd;
        logic signed [SUM_W-1:0] lim;
        logic signed [SUM_W-1:0] r;
        rnd = SUM_W'(1 << (Q_FRAC - 1));
        lim = SUM_W'(limit);
        r   = (s + rnd) >>> Q_FRAC;
        if (r > lim) begin
            r = lim;
        end else if (r < -lim) begin
            r = -lim;
        end
        return r[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mul_s16x17.sv
// Registered signed 16x17 multiplier; the product holds while en is low.
module mul_s16x17
    import foc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [DATA_W-1:0]  a,
    input  logic signed [ANGLE_W-1:0] b,
    output logic signed [PROD_W-1:0]  p
);

    logic signed [PROD_W-1:0] p_d;
    logic signed [PROD_W-1:0] p_q;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = PROD_W'(a) * PROD_W'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/inv_park.sv
// Inverse Park transform (vd,vq,angle) -> (alpha,beta) with one time-shared
// multiplier; fixed 7-cycle schedule IDLE->M0..M3->SUM->OUT.
module inv_park
    import foc_pkg::*;
#(
    parameter int OUT_LIMIT = 32767
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AB_W-1:0] s_vdq_tdata,
    input  logic            s_vdq_tvalid,
    input  logic [SC_W-1:0] sin_cos_tdata,
    input  logic            sin_cos_tvalid,
    output logic [AB_W-1:0] alpha_beat_tdata,
    output logic            alpha_beat_tvalid,
    output logic            busy,
    output logic            overrun
);

    inv_park_state_e state_q, state_d;

    logic [AB_W-1:0]             vdq_q, vdq_d, vdq_live;
    logic signed [DATA_W-1:0]    op_vd_q, op_vd_d, op_vq_q, op_vq_d;
    logic signed [ANGLE_W-1:0]   op_sin_q, op_sin_d, op_cos_q, op_cos_d;
    logic signed [PROD_W-1:0]    prod0_q, prod0_d, prod1_q, prod1_d, prod2_q, prod2_d;
    logic signed [DATA_W-1:0]    alpha_q, alpha_d, beta_q, beta_d;
    logic [AB_W-1:0]             ab_tdata_q, ab_tdata_d;
    logic                        ab_tvalid_q, ab_tvalid_d;
    logic                        overrun_q, overrun_d;

    logic                        trigger;
    logic                        mul_en;
    logic signed [DATA_W-1:0]    mul_a;
    logic signed [ANGLE_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]    mul_p;
    logic signed [SUM_W-1:0]     alpha_sum, beta_sum;

    assign trigger  = sin_cos_tvalid && (state_q == ST_IDLE);
    assign vdq_live = s_vdq_tvalid ? s_vdq_tdata : vdq_q;

    mul_s16x17 u_mul (
        .clk (clk),
        .rst (rst),
        .en  (mul_en),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (trigger) state_d = ST_M0;
            ST_M0:   state_d = ST_M1;
            ST_M1:   state_d = ST_M2;
            ST_M2:   state_d = ST_M3;
            ST_M3:   state_d = ST_SUM;
            ST_SUM:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand steering: one product per M-state, result visible one state later.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        mul_en = 1'b0;
        mul_a  = op_vd_q;
        mul_b  = op_cos_q;
        unique case (state_q)
            ST_M0: begin mul_en = 1'b1; mul_a = op_vd_q; mul_b = op_cos_q; end
            ST_M1: begin mul_en = 1'b1; mul_a = op_vq_q; mul_b = op_sin_q; end
            ST_M2: begin mul_en = 1'b1; mul_a = op_vd_q; mul_b = op_sin_q; end
            ST_M3: begin mul_en = 1'b1; mul_a = op_vq_q; mul_b = op_cos_q; end
            default: ;
        endcase
    end

    // In SUM the multiplier still holds vq*cos from M3.
    assign alpha_sum = SUM_W'(prod0_q) - SUM_W'(prod1_q);
    assign beta_sum  = SUM_W'(prod2_q) + SUM_W'(mul_p);

    always_comb begin
        vdq_d       = s_vdq_tvalid ? s_vdq_tdata : vdq_q;
        op_vd_d     = op_vd_q;
        op_vq_d     = op_vq_q;
        op_sin_d    = op_sin_q;
        op_cos_d    = op_cos_q;
        prod0_d     = prod0_q;
        prod1_d     = prod1_q;
        prod2_d     = prod2_q;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        ab_tdata_d  = ab_tdata_q;
        ab_tvalid_d = (state_q == ST_OUT);
        overrun_d   = overrun_q | (sin_cos_tvalid && busy);
        if (trigger) begin
            op_vd_d  = vdq_live[VDQ_VD_LSB +: DATA_W];
            op_vq_d  = vdq_live[VDQ_VQ_LSB +: DATA_W];
            op_sin_d = sin_cos_tdata[SC_SIN_LSB +: ANGLE_W];
            op_cos_d = sin_cos_tdata[SC_COS_LSB +: ANGLE_W];
        end
        unique case (state_q)
            ST_M1:  prod0_d = mul_p;
            ST_M2:  prod1_d = mul_p;
            ST_M3:  prod2_d = mul_p;
            ST_SUM: begin
                alpha_d = round_sat(alpha_sum, OUT_LIMIT);
                beta_d  = round_sat(beta_sum, OUT_LIMIT);
            end
            ST_OUT: ab_tdata_d = {alpha_q, beta_q};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vdq_q       <= '0;
            op_vd_q     <= '0;
            op_vq_q     <= '0;
            op_sin_q    <= '0;
            op_cos_q    <= '0;
            prod0_q     <= '0;
            prod1_q     <= '0;
            prod2_q     <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            ab_tdata_q  <= '0;
            ab_tvalid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            vdq_q       <= vdq_d;
            op_vd_q     <= op_vd_d;
            op_vq_q     <= op_vq_d;
            op_sin_q    <= op_sin_d;
            op_cos_q    <= op_cos_d;
            prod0_q     <= prod0_d;
            prod1_q     <= prod1_d;
            prod2_q     <= prod2_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            ab_tdata_q  <= ab_tdata_d;
            ab_tvalid_q <= ab_tvalid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign alpha_beat_tdata  = ab_tdata_q;
    assign alpha_beat_tvalid = ab_tvalid_q;
    assign overrun           = overrun_q;

endmodule
